// File: rtl/llc_output_encoder_pkg.sv
// Shared types and encodings for the LLC output encoder.
// The message structs are sized from LLC_N_L2; the top-level N_L2 parameter must match it.
package llc_output_encoder_pkg;

  localparam int LLC_N_L2   = 4;
  localparam int LLC_DEST_W = $clog2(LLC_N_L2);
  localparam int ADDR_W     = 28;
  localparam int LINE_W     = 64;

  typedef logic [ADDR_W-1:0]     line_addr_t;
  typedef logic [LINE_W-1:0]     line_t;
  typedef logic [2:0]            coh_msg_t;
  typedef logic [LLC_DEST_W-1:0] cache_id_t;
  typedef logic [LLC_N_L2-1:0]   sharers_t;

  typedef enum logic [2:0] {
    OP_RSP     = 3'd0,
    OP_FWD     = 3'd1,
    OP_MEM_RD  = 3'd2,
    OP_MEM_WB  = 3'd3,
    OP_DMA_RSP = 3'd4,
    OP_INV     = 3'd5
  } llc_out_op_t;

  localparam coh_msg_t FWD_INV = 3'd2;

  typedef struct packed {
    llc_out_op_t op;
    coh_msg_t    coh_msg;
    line_addr_t  addr;
    line_t       line;
    cache_id_t   dest;
    sharers_t    sharers;
  } llc_out_cmd_t;

  typedef struct packed {
    coh_msg_t   coh_msg;
    line_addr_t addr;
    line_t      line;
    cache_id_t  dest;
  } llc_rsp_out_t;

  typedef struct packed {
    coh_msg_t   coh_msg;
    line_addr_t addr;
    cache_id_t  dest;
  } llc_fwd_out_t;

  typedef struct packed {
    logic       hwrite;
    line_addr_t addr;
    line_t      line;
  } llc_mem_req_t;

  typedef struct packed {
    line_addr_t addr;
    line_t      line;
  } llc_dma_rsp_t;

endpackage

// File: rtl/llc_output_encoder_fifo.sv
// Per-channel FIFO (module llc_out_fifo) with extra-MSB pointers for full/empty.
// DEPTH must be a power of two and at least 2.
module llc_out_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     data_in,
  output T     data_out,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          push_en, pop_en;
  T              mem [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_en  = push && (!full || pop);
  assign pop_en   = pop && !empty;
  assign data_out = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_en);
    rd_ptr_d = rd_ptr_q + PW'(pop_en);
  end

  // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is intentionally not reset; the pointers alone decide which entries are live, so the array needs no reset net.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/llc_output_encoder.sv
// LLC output encoder: routes one command per cycle to rsp/fwd/mem/dma FIFOs and fans invalidates out per sharer.
// Define LLC_OUT_BYPASS_EN to drive single ops straight to an empty, ready channel in the acceptance cycle.
module llc_output_encoder
  import llc_output_encoder_pkg::*;
#(
  parameter int N_L2       = LLC_N_L2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  llc_out_cmd_t cmd,
  output logic         rsp_out_valid,
  input  logic         rsp_out_ready,
  output llc_rsp_out_t rsp_out,
  output logic         fwd_out_valid,
  input  logic         fwd_out_ready,
  output llc_fwd_out_t fwd_out,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output llc_mem_req_t mem_req,
  output logic         dma_rsp_valid,
  input  logic         dma_rsp_ready,
  output llc_dma_rsp_t dma_rsp,
  output logic         idle
);

  localparam int DEST_W = $clog2(N_L2);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_FANOUT = 1'b1;

  logic            state_q, state_d;
  logic [N_L2-1:0] mask_q, mask_d;
  line_addr_t      inv_addr_q, inv_addr_d;

  logic rsp_full, rsp_empty, rsp_push, rsp_pop, rsp_byp;
  logic fwd_full, fwd_empty, fwd_push, fwd_pop, fwd_byp;
  logic mem_full, mem_empty, mem_push, mem_pop, mem_byp;
  logic dma_full, dma_empty, dma_push, dma_pop, dma_byp;

  llc_rsp_out_t rsp_msg, rsp_fifo_out;
  llc_fwd_out_t cmd_fwd_msg, fan_msg, fwd_push_msg, fwd_fifo_out;
  llc_mem_req_t mem_msg, mem_fifo_out;
  llc_dma_rsp_t dma_msg, dma_fifo_out;

  logic tgt_rsp, tgt_fwd, tgt_mem, tgt_dma, is_inv;
  logic in_idle, cmd_acc;
  logic can_push_rsp, can_push_fwd, can_push_mem, can_push_dma;
  logic [N_L2-1:0]   mask_new, mask_cur, low_bit;
  logic [DEST_W-1:0] low_idx;
  logic              fan_req, fan_push;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    tgt_rsp = 1'b0;
    tgt_fwd = 1'b0;
    tgt_mem = 1'b0;
    tgt_dma = 1'b0;
    is_inv  = 1'b0;
    case (cmd.op)
      OP_RSP:               tgt_rsp = 1'b1;
      OP_FWD:               tgt_fwd = 1'b1;
      OP_MEM_RD, OP_MEM_WB: tgt_mem = 1'b1;
      OP_DMA_RSP:           tgt_dma = 1'b1;
      OP_INV:               is_inv  = 1'b1;
      default: ;
    endcase
  end

  assign rsp_pop = !rsp_empty && rsp_out_ready;
  assign fwd_pop = !fwd_empty && fwd_out_ready;
  assign mem_pop = !mem_empty && mem_req_ready;
  assign dma_pop = !dma_empty && dma_rsp_ready;

  assign can_push_rsp = !rsp_full || rsp_pop;
  assign can_push_fwd = !fwd_full || fwd_pop;
  assign can_push_mem = !mem_full || mem_pop;
  assign can_push_dma = !dma_full || dma_pop;

  // Gating with rst keeps cmd_ready low for the whole reset, not just after the first edge.
  assign in_idle   = !rst && (state_q == ST_IDLE);
  assign cmd_ready = in_idle && (tgt_rsp ? can_push_rsp :
                                 tgt_fwd ? can_push_fwd :
                                 tgt_mem ? can_push_mem :
                                 tgt_dma ? can_push_dma : 1'b1);
  assign cmd_acc   = cmd_valid && cmd_ready;

  assign rsp_msg     = '{coh_msg: cmd.coh_msg, addr: cmd.addr, line: cmd.line, dest: cmd.dest};
  assign cmd_fwd_msg = '{coh_msg: cmd.coh_msg, addr: cmd.addr, dest: cmd.dest};
  assign mem_msg     = '{hwrite: (cmd.op == OP_MEM_WB), addr: cmd.addr,
                         line: (cmd.op == OP_MEM_WB) ? cmd.line : '0};
  assign dma_msg     = '{addr: cmd.addr, line: cmd.line};

`ifdef LLC_OUT_BYPASS_EN
  assign rsp_byp = cmd_acc && tgt_rsp && rsp_empty && rsp_out_ready;
  assign fwd_byp = cmd_acc && tgt_fwd && fwd_empty && fwd_out_ready;
  assign mem_byp = cmd_acc && tgt_mem && mem_empty && mem_req_ready;
  assign dma_byp = cmd_acc && tgt_dma && dma_empty && dma_rsp_ready;
`else
  assign rsp_byp = 1'b0;
  assign fwd_byp = 1'b0;
  assign mem_byp = 1'b0;
  assign dma_byp = 1'b0;
`endif

  // The first invalidate is pushed in the acceptance cycle from the live command.
  assign mask_new = cmd.sharers & ~(N_L2'(1) << cmd.dest);
  assign mask_cur = (state_q == ST_IDLE) ? mask_new : mask_q;

  always_comb begin
    low_idx = '0;
    for (int i = N_L2 - 1; i >= 0; i--) begin
      if (mask_cur[i]) low_idx = DEST_W'(i);
    end
  end

  assign low_bit  = N_L2'(1) << low_idx;
  assign fan_req  = (state_q == ST_IDLE) ? (cmd_acc && is_inv && (mask_new != '0))
                                         : (mask_q != '0);
  assign fan_push = fan_req && can_push_fwd;
  assign fan_msg  = '{coh_msg: FWD_INV,
                      addr:    (state_q == ST_IDLE) ? cmd.addr : inv_addr_q,
                      dest:    cache_id_t'(low_idx)};

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    inv_addr_d = inv_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc && is_inv && (mask_new != '0)) begin
          state_d    = ST_FANOUT;
          inv_addr_d = cmd.addr;
          mask_d     = fan_push ? (mask_new & ~low_bit) : mask_new;
        end
      end
      ST_FANOUT: begin
        if (mask_q == '0)  state_d = ST_IDLE;
        else if (fan_push) mask_d  = mask_q & ~low_bit;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      inv_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      inv_addr_q <= inv_addr_d;
    end
  end

  assign rsp_push     = cmd_acc && tgt_rsp && !rsp_byp;
  assign fwd_push     = fan_push || (cmd_acc && tgt_fwd && !fwd_byp);
  assign mem_push     = cmd_acc && tgt_mem && !mem_byp;
  assign dma_push     = cmd_acc && tgt_dma && !dma_byp;
  assign fwd_push_msg = fan_push ? fan_msg : cmd_fwd_msg;

  llc_out_fifo #(.T(llc_rsp_out_t), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk(clk), .rst(rst), .push(rsp_push), .pop(rsp_pop), .data_in(rsp_msg),
    .data_out(rsp_fifo_out), .full(rsp_full), .empty(rsp_empty));

  llc_out_fifo #(.T(llc_fwd_out_t), .DEPTH(FIFO_DEPTH)) u_fwd_fifo (
    .clk(clk), .rst(rst), .push(fwd_push), .pop(fwd_pop), .data_in(fwd_push_msg),
    .data_out(fwd_fifo_out), .full(fwd_full), .empty(fwd_empty));

  llc_out_fifo #(.T(llc_mem_req_t), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk(clk), .rst(rst), .push(mem_push), .pop(mem_pop), .data_in(mem_msg),
    .data_out(mem_fifo_out), .full(mem_full), .empty(mem_empty));

  llc_out_fifo #(.T(llc_dma_rsp_t), .DEPTH(FIFO_DEPTH)) u_dma_fifo (
    .clk(clk), .rst(rst), .push(dma_push), .pop(dma_pop), .data_in(dma_msg),
    .data_out(dma_fifo_out), .full(dma_full), .empty(dma_empty));

  // Payloads read as zero whenever nothing is offered on the channel.
  assign rsp_out_valid = !rsp_empty || rsp_byp;
  assign fwd_out_valid = !fwd_empty || fwd_byp;
  assign mem_req_valid = !mem_empty || mem_byp;
  assign dma_rsp_valid = !dma_empty || dma_byp;

  assign rsp_out = !rsp_empty ? rsp_fifo_out : (rsp_byp ? rsp_msg     : '0);
  assign fwd_out = !fwd_empty ? fwd_fifo_out : (fwd_byp ? cmd_fwd_msg : '0);
  assign mem_req = !mem_empty ? mem_fifo_out : (mem_byp ? mem_msg     : '0);
  assign dma_rsp = !dma_empty ? dma_fifo_out : (dma_byp ? dma_msg     : '0);

  assign idle = in_idle && rsp_empty && fwd_empty && mem_empty && dma_empty;

endmodule

// File: doc/llc_output_encoder.md
# llc_output_encoder

Output-side counterpart of the LLC input decoder. It accepts one command per cycle from the LLC main FSM and encodes it into one of four outgoing channels: rsp_out, fwd_out, mem_req and dma_rsp. Each channel has its own FIFO. Invalidate commands expand into one fwd_out message per sharer. Sits between the LLC core and the NoC/memory interface queues.

## Interface
- N_L2, default 4: number of L2 caches; sets the sharer-vector width.
- FIFO_DEPTH, default 2: entries per channel FIFO; must be a power of two and at least 2.
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd  in  llc_out_cmd_t  fields: op, coh_msg, addr (line_addr_t), line (line_t), dest ($clog2(N_L2)), sharers (N_L2)
- rsp_out_valid / rsp_out_ready  out/in  1  rsp_out handshake
- rsp_out  out  llc_rsp_out_t  fields: coh_msg, addr, line, dest
- fwd_out_valid / fwd_out_ready  out/in  1  fwd_out handshake
- fwd_out  out  llc_fwd_out_t  fields: coh_msg, addr, dest
- mem_req_valid / mem_req_ready  out/in  1  mem_req handshake
- mem_req  out  llc_mem_req_t  fields: hwrite, addr, line
- dma_rsp_valid / dma_rsp_ready  out/in  1  dma_rsp handshake
- dma_rsp  out  llc_dma_rsp_t  fields: addr, line
- idle  out  1  FSM is in IDLE and all FIFOs are empty

## Operation
- Ops, as llc_out_op_t, 3 bits:
  - OP_RSP, OP_FWD, OP_MEM_RD, OP_MEM_WB, OP_DMA_RSP: each is a single message on its channel.
  - OP_MEM_RD sets hwrite=0 and drives line as zero.
  - OP_MEM_WB sets hwrite=1.
  - OP_INV is a fan-out op.
- Single ops:
  - cmd_ready = (state==IDLE) && target FIFO not full.
  - On acceptance the message is pushed into the target FIFO.
- OP_INV:
  - cmd_ready = (state==IDLE).
  - On acceptance, latch mask = sharers & ~onehot(dest) and latch addr.
  - If mask==0, the command is consumed, no message is sent, and the FSM stays IDLE.
  - Otherwise the FSM goes to FANOUT.
- FANOUT:
  - cmd_ready=0.
  - Each cycle the fwd FIFO is not full, push {coh_msg=FWD_INV, addr, dest=index of the lowest set mask bit} and clear that bit.
  - When the final bit is cleared, return to IDLE the next cycle.
- Order is preserved within each channel; there is no ordering between channels.
- Downstream handshake: valid is held with its payload stable until ready is sampled high. The FIFO pops on valid && ready.
- FIFO full: the command stalls via cmd_ready=0. Nothing is dropped.

## Timing
- While rst is high, and on its release, the following outputs are 0: all *_valid, cmd_ready, and all payload fields.
- idle is 0 while rst is high, and 1 from the first cycle after release.
- FSM resets to IDLE, mask to 0, FIFO pointers to 0.
- Reset asserted mid-FANOUT aborts the fan-out; pending messages are discarded.
- Latency without bypass: a command accepted in cycle N shows valid on its channel in cycle N+1.
- Fan-out of k sharers with ready held high: messages are valid in cycles N+1 through N+k. cmd_ready returns in cycle N+k+1.
- FIFO full and pop in the same cycle: the push is allowed, and cmd_ready sees not-full.
- Pointers are $clog2(FIFO_DEPTH)+1 bits. Full means the MSBs differ and the remaining bits are equal. Pointers wrap naturally.

## Configuration
- LLC_OUT_BYPASS_EN defined:
  - A single op whose target FIFO is empty and whose downstream ready is high is driven combinationally in the acceptance cycle, with no push (0-cycle latency).
  - Fan-out messages are never bypassed.
- LLC_OUT_BYPASS_EN undefined: every message goes through its FIFO with 1-cycle minimum latency.

## Structure
- cache_types.svh: llc_out_op_t, llc_out_cmd_t, llc_rsp_out_t, llc_fwd_out_t, llc_mem_req_t, llc_dma_rsp_t.
- cache_consts.svh: FWD_INV and the op encodings.
- Sub-module llc_out_fifo: parameterized on payload type and FIFO_DEPTH, instantiated once per channel. Ports: push, pop, data_in, data_out, full, empty.
- Fan-out FSM, mask register and priority encoder live in the top module.

## Test plan
- OP_RSP with addr=0x1234 and rsp_out_ready=1: rsp_out_valid is high in cycle N+1 with addr 0x1234 and dest echoed. With the macro defined, it is valid in cycle N.
- OP_INV with sharers=4'b1011 and dest=1: fwd_out carries dest 0 then dest 3 (2 messages), and cmd_ready returns after the second.
- OP_INV with sharers=4'b0100 and dest=2: no fwd_out activity, cmd_ready stays 1, idle stays 1.
- mem_req_ready=0 and 3 OP_MEM_WB with FIFO_DEPTH=2: cmd_ready drops after 2 are accepted. Raise ready: 3 writebacks leave in order with hwrite=1.
- Mid-fan-out reset with sharers=4'hF and dest=0 (1 message sent): all valids go to 0 and idle=1 one cycle after release.
- Concurrent stall: fwd_out_ready=0 during FANOUT while rsp_out drains previously queued entries, with the rsp_out payload stable.
